// File: rtl/lenet_pkg.sv
// Shared constants for the LeNet layer-7 weight path.
// Holds ROM geometry, default read latency and fetch FSM encoding.
package lenet_pkg;

   localparam int W7_AW       = 7;
   localparam int W7_DW       = 80;
   localparam int W7_DEPTH    = 128;
   localparam int W7_READ_LAT = 1;

   typedef logic [1:0] w7_state_t;

   localparam w7_state_t ST_IDLE  = 2'd0;
   localparam w7_state_t ST_FETCH = 2'd1;
   localparam w7_state_t ST_DRAIN = 2'd2;
   localparam w7_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/w7_fetch_ctrl_if.sv
// Weight-row stream from the fetch controller to the FC7 MAC array.
// master: wt_data/wt_valid/wt_last out, wt_ready in; slave: mirror.
interface w7_fetch_ctrl_if
   import lenet_pkg::*;
#(
   parameter int DW = W7_DW
);

   logic [DW-1:0] wt_data;
   logic          wt_valid;
   logic          wt_ready;
   logic          wt_last;

   modport master (
      output wt_data,
      output wt_valid,
      output wt_last,
      input  wt_ready
   );

   modport slave (
      input  wt_data,
      input  wt_valid,
      input  wt_last,
      output wt_ready
   );

endinterface

// File: rtl/w7_skid_fifo.sv
// First-word-fall-through FIFO absorbing ROM rows under back-pressure.
// push_i/din_i in, pop_i in, dout_o head, count_o/full_o/empty_o status.
module w7_skid_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 81,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic [CW-1:0]    count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_q;
   logic [PW-1:0]    rd_q;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] nxt(
      input logic [PW-1:0] p
   );
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign count_o = cnt_q;
   assign dout_o  = mem_q[rd_q];

   assign do_pop  = pop_i & ~empty_o;
   // A push into a full FIFO is fine when the head leaves this cycle.
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      cnt_d = cnt_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (do_push) wr_q <= nxt(wr_q);
         if (do_pop)  rd_q <= nxt(rd_q);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

endmodule

// File: rtl/w7_fetch_ctrl.sv
// Walks num_rows ROM rows from base_addr and streams them to the MAC.
// Ports: start/base_addr/num_rows job, w7_raddr/w7_rdata ROM, wt stream.
module w7_fetch_ctrl
   import lenet_pkg::*;
#(
   parameter int AW         = W7_AW,
   parameter int DW         = W7_DW,
   parameter int READ_LAT   = W7_READ_LAT,
   parameter int FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [AW-1:0]   base_addr,
   input  logic [AW:0]     num_rows,
   output logic [AW-1:0]   w7_raddr,
   input  logic [DW-1:0]   w7_rdata,
   w7_fetch_ctrl_if.master wt,
   output logic            busy,
   output logic            done
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int OW = 8;

   w7_state_t     state_q;
   w7_state_t     state_d;
   logic [AW-1:0] base_q;
   logic [AW:0]   num_q;
   logic [AW:0]   issued_q;
   logic [AW:0]   issued_d;
   logic [AW-1:0] raddr_q;
   logic [AW-1:0] raddr_d;

   // Stage 0 marks the address register; stage READ_LAT marks rdata.
   logic [READ_LAT:0] vld_q;
   logic [READ_LAT:0] lst_q;

   logic          fetch_en;
   logic          start_ok;
   logic          issue;
   logic          last_issue;
   logic          pop;
   logic          push;
   logic [OW-1:0] inflight;
   logic [OW-1:0] occ;
   logic          credit_ok;

   logic [DW:0]   fifo_dout;
   logic [CW-1:0] fifo_cnt;
   logic          fifo_full;
   logic          fifo_empty;

   assign start_ok = (state_q == ST_IDLE) & start;
   assign pop      = wt.wt_valid & wt.wt_ready;
   assign push     = vld_q[READ_LAT];

   always_comb begin
      inflight = '0;
      for (int i = 0; i <= READ_LAT; i++) begin
         inflight = inflight + OW'(vld_q[i]);
      end
   end

   // Rows already owed to the FIFO plus the new one must fit.
   assign occ = OW'(fifo_cnt) + inflight - OW'(pop);
   assign credit_ok = (occ < OW'(FIFO_DEPTH))
                    & ~(fifo_full & ~pop);

   assign issue      = fetch_en & credit_ok;
   assign last_issue = issue
                     & (issued_q == num_q - (AW+1)'(1));

   always_comb begin
      issued_d = issued_q;
      raddr_d  = raddr_q;
      if (start_ok) begin
         issued_d = '0;
      end else if (issue) begin
         issued_d = issued_q + (AW+1)'(1);
      end
      if (issue) begin
         raddr_d = base_q + issued_q[AW-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = (num_rows == '0) ? ST_DONE
                                          : ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (last_issue) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (pop & wt.wt_last) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      fetch_en = (state_q == ST_FETCH);
      busy     = (state_q != ST_IDLE);
      done     = (state_q == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         base_q   <= '0;
         num_q    <= '0;
         issued_q <= '0;
         raddr_q  <= '0;
         vld_q    <= '0;
         lst_q    <= '0;
      end else begin
         if (start_ok) begin
            base_q <= base_addr;
            num_q  <= num_rows;
         end
         issued_q <= issued_d;
         raddr_q  <= raddr_d;
         vld_q    <= {vld_q[READ_LAT-1:0], issue};
         lst_q    <= {lst_q[READ_LAT-1:0], last_issue};
      end
   end

   assign w7_raddr = raddr_q;

   w7_skid_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DW + 1)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .din_i   ({lst_q[READ_LAT], w7_rdata}),
      .pop_i   (pop),
      .dout_o  (fifo_dout),
      .count_o (fifo_cnt),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign wt.wt_valid = ~fifo_empty;
   assign wt.wt_data  = fifo_dout[DW-1:0];
   assign wt.wt_last  = ~fifo_empty & fifo_dout[DW];

endmodule

// File: tb/tb_w7_fetch_ctrl.sv
// Scoreboard bench for w7_fetch_ctrl at READ_LAT 1 and 2 in parallel.
// Both instances share job stimulus and wt_ready.
`timescale 1ns/1ps
module tb_w7_fetch_ctrl;
   import lenet_pkg::*;

   localparam int AW = W7_AW;
   localparam int DW = W7_DW;
   localparam int NI = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          wt_ready = 1'b1;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   num_rows = '0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int start_cyc = 0;
   bit chk_lat = 1'b0;
   bit zero_job = 1'b0;
   bit rdy_rand = 1'b0;
   bit rdy_const = 1'b1;
   int rdy_pct = 100;

   logic          v_valid [NI];
   logic          v_last  [NI];
   logic          v_busy  [NI];
   logic          v_done  [NI];
   logic [AW-1:0] v_raddr [NI];
   logic [DW-1:0] v_data  [NI];
   logic [2:0]    v_cnt   [NI];

   logic [AW:0]   exp_q [NI][$];
   int            done_cnt  [NI];
   int            prev_done [NI];
   int            rows      [NI];
   int            last_cyc  [NI];
   bit            seen      [NI];
   bit            gap       [NI];
   bit            got_last  [NI];
   bit            stall_q   [NI];
   logic [DW-1:0] hold_d    [NI];
   logic          hold_l    [NI];

   function automatic logic [DW-1:0] rowval(input int k);
      logic [7:0] b;
      b = 8'(k);
      return {10{b}};
   endfunction

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) wt_ready = ($urandom_range(0, 99) < rdy_pct);
      else          wt_ready = rdy_const;
   end

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int LAT = g + 1;
      w7_fetch_ctrl_if #(.DW(DW)) wif ();
      logic [AW-1:0] raddr;
      logic [DW-1:0] rdata;
      logic [DW-1:0] rom_q;
      logic          bsy;
      logic          dn;

      assign wif.wt_ready = wt_ready;

      w7_fetch_ctrl #(
         .AW(AW), .DW(DW),
         .READ_LAT(LAT), .FIFO_DEPTH(4)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .start     (start),
         .base_addr (base_addr),
         .num_rows  (num_rows),
         .w7_raddr  (raddr),
         .w7_rdata  (rdata),
         .wt        (wif),
         .busy      (bsy),
         .done      (dn)
      );

      always @(posedge clk) rom_q <= rowval(int'(raddr));

      if (LAT == 1) begin : g_l1
         assign rdata = rom_q;
      end else begin : g_l2
         logic [DW-1:0] oreg;
         always @(posedge clk) oreg <= rom_q;
         assign rdata = oreg;
      end

      assign v_valid[g] = wif.wt_valid;
      assign v_last[g]  = wif.wt_last;
      assign v_data[g]  = wif.wt_data;
      assign v_busy[g]  = bsy;
      assign v_done[g]  = dn;
      assign v_raddr[g] = raddr;
      assign v_cnt[g]   = u_dut.fifo_cnt;
   end

   task automatic chk(input string nm,
                      input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: pops the scoreboard on every handshake.
   initial forever begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
         if (!rst_n) begin
            stall_q[g] = 1'b0;
         end else begin
            if (v_cnt[g] > 3'd4) begin
               errors++;
               $display("FAIL fifo_ovf%0d: count %0d limit 4",
                        g, v_cnt[g]);
            end
            if (stall_q[g]) begin
               chk($sformatf("stall_valid%0d", g), v_valid[g], 1);
               chk($sformatf("stall_data%0d", g), v_data[g], hold_d[g]);
               chk($sformatf("stall_last%0d", g), v_last[g], hold_l[g]);
            end
            if (chk_lat && seen[g] && !got_last[g] && !v_valid[g])
               gap[g] = 1'b1;
            if (v_valid[g] && !seen[g]) begin
               seen[g] = 1'b1;
               if (chk_lat)
                  chk($sformatf("latency%0d", g), cyc - start_cyc, g + 3);
            end
            if (v_valid[g] && wt_ready) begin
               if (exp_q[g].size() == 0) begin
                  errors++;
                  $display("FAIL unexpected%0d: row %0h with empty queue",
                           g, v_data[g]);
               end else begin
                  logic [AW:0] e;
                  e = exp_q[g].pop_front();
                  chk($sformatf("row_data%0d", g), v_data[g],
                      rowval(int'(e[AW-1:0])));
                  chk($sformatf("row_last%0d", g), v_last[g], e[AW]);
               end
               rows[g]++;
               if (v_last[g]) begin
                  got_last[g] = 1'b1;
                  last_cyc[g] = cyc;
               end
            end
            if (v_done[g]) begin
               chk($sformatf("done_empty%0d", g), exp_q[g].size(), 0);
               chk($sformatf("done_time%0d", g), cyc,
                   zero_job ? start_cyc : last_cyc[g] + 1);
               if (chk_lat)
                  chk($sformatf("no_gap%0d", g), gap[g], 0);
               done_cnt[g]++;
            end
            stall_q[g] = v_valid[g] & ~wt_ready;
            hold_d[g]  = v_data[g];
            hold_l[g]  = v_last[g];
         end
      end
   end

   // Reference: a job of n rows is addresses (b+k) mod 128, last at k=n-1.
   task automatic job(input int b, input int n, input bit acc);
      base_addr = AW'(b);
      num_rows  = (AW+1)'(n);
      start     = 1'b1;
      if (acc) begin
         for (int g = 0; g < NI; g++) begin
            prev_done[g] = done_cnt[g];
            seen[g]      = 1'b0;
            gap[g]       = 1'b0;
            got_last[g]  = 1'b0;
            rows[g]      = 0;
            last_cyc[g]  = -100;
         end
      end
      tick(1);
      start = 1'b0;
      if (acc) begin
         start_cyc = cyc;
         zero_job  = (n == 0);
         for (int g = 0; g < NI; g++) begin
            for (int k = 0; k < n; k++) begin
               exp_q[g].push_back({k == n - 1, AW'((b + k) % 128)});
            end
         end
      end
   endtask

   task automatic wait_done(input string nm);
      int i;
      i = 0;
      while (!(done_cnt[0] > prev_done[0] &&
               done_cnt[1] > prev_done[1]) && i < 4000) begin
         tick(1);
         i++;
      end
      checks++;
      if (i >= 4000) begin
         errors++;
         $display("FAIL %s_timeout: got no done expected done in 4000 cycles",
                  nm);
      end else begin
         tick(1);
         for (int g = 0; g < NI; g++)
            chk($sformatf("%s_idle%0d", nm, g), v_busy[g], 0);
      end
   endtask

   task automatic chk_reset(input string nm);
      for (int g = 0; g < NI; g++) begin
         chk($sformatf("%s_raddr%0d", nm, g), v_raddr[g], 0);
         chk($sformatf("%s_valid%0d", nm, g), v_valid[g], 0);
         chk($sformatf("%s_last%0d", nm, g), v_last[g], 0);
         chk($sformatf("%s_busy%0d", nm, g), v_busy[g], 0);
         chk($sformatf("%s_done%0d", nm, g), v_done[g], 0);
      end
   endtask

   initial begin
      logic [AW-1:0] r_save [NI];
      int dc [NI];
      int i;

      rst_n = 1'b0;
      tick(3);
      chk_reset("rst");
      rst_n = 1'b1;
      tick(2);

      // Full-rate job, latency and gapless stream.
      chk_lat = 1'b1;
      job(0, 84, 1);
      for (int g = 0; g < NI; g++)
         chk($sformatf("busy_start%0d", g), v_busy[g], 1);
      wait_done("t1");

      // Address wrap 127 -> 0.
      job(120, 16, 1);
      wait_done("t2");
      chk_lat = 1'b0;

      // Empty job.
      for (int g = 0; g < NI; g++) r_save[g] = v_raddr[g];
      job(9, 0, 1);
      for (int g = 0; g < NI; g++) begin
         chk($sformatf("zero_done%0d", g), v_done[g], 1);
         chk($sformatf("zero_busy%0d", g), v_busy[g], 1);
         chk($sformatf("zero_valid%0d", g), v_valid[g], 0);
      end
      tick(1);
      for (int g = 0; g < NI; g++) begin
         chk($sformatf("zero_done_off%0d", g), v_done[g], 0);
         chk($sformatf("zero_busy_off%0d", g), v_busy[g], 0);
         chk($sformatf("zero_raddr%0d", g), v_raddr[g], r_save[g]);
         chk($sformatf("zero_cnt%0d", g), done_cnt[g], prev_done[g] + 1);
      end

      // Random back-pressure.
      rdy_rand = 1'b1;
      rdy_pct  = 30;
      job($urandom_range(0, 127), 20, 1);
      wait_done("t4");

      // Second start while busy is ignored.
      rdy_pct = 50;
      job(60, 40, 1);
      tick(6);
      job(5, 9, 0);
      wait_done("t5");

      // Reset mid-job.
      rdy_rand = 1'b0;
      job(30, 50, 1);
      i = 0;
      while (rows[0] < 10 && i < 2000) begin
         tick(1);
         i++;
      end
      checks++;
      if (i >= 2000) begin
         errors++;
         $display("FAIL t6_rows: got %0d rows expected 10", rows[0]);
      end
      rst_n = 1'b0;
      tick(1);
      chk_reset("midrst");
      rst_n = 1'b1;
      for (int g = 0; g < NI; g++) begin
         exp_q[g].delete();
         dc[g] = done_cnt[g];
      end
      tick(20);
      for (int g = 0; g < NI; g++)
         chk($sformatf("midrst_nodone%0d", g), done_cnt[g], dc[g]);
      job(100, 12, 1);
      wait_done("t6");

      // Random jobs, including a full sweep.
      rdy_rand = 1'b1;
      rdy_pct  = 70;
      for (int j = 0; j < 6; j++) begin
         job($urandom_range(0, 127),
             (j == 0) ? 128 : $urandom_range(1, 128), 1);
         wait_done("t7");
      end

      tick(3);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
